// File: rtl/input_pkg.sv
// input_pkg: shared types and sizing helpers for the button debouncer
package input_pkg;

   typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} repeat_state_t;

   // Bits needed to hold values 0..n; never narrower than one bit
   function automatic int cnt_width(input int n);
      return (n < 1) ? 1 : $clog2(n + 1);
   endfunction

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one-bit debouncer with press/release pulses and auto-repeat
module debounce_channel
   import input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES      = 1000000,
   parameter int REPEAT_DELAY_CYCLES  = 50000000,
   parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
   input  logic clk_in,
   input  logic rst_in,
   input  logic data_in,
   output logic level_out,
   output logic press_out,
   output logic release_out,
   output logic repeat_out
);

   localparam int DW = cnt_width(DEBOUNCE_CYCLES);
   localparam int RW = cnt_width(max2(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES));
   localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_LOAD = RW'((REPEAT_DELAY_CYCLES > 0) ? REPEAT_DELAY_CYCLES - 1 : 0);
   localparam logic [RW-1:0] PER_LOAD = RW'((REPEAT_PERIOD_CYCLES > 0) ? REPEAT_PERIOD_CYCLES - 1 : 0);
   localparam logic          RPT_EN   = REPEAT_DELAY_CYCLES > 0;

   logic [DW-1:0] cnt_d, cnt_q;
   logic [RW-1:0] rpt_cnt_d, rpt_cnt_q;
   logic          level_d, level_q;
   logic          press_d, press_q;
   logic          release_d, release_q;
   logic          repeat_d, repeat_q;
   repeat_state_t state_d, state_q;

   // Count consecutive samples that disagree with the stable level; accept on the last one
   always_comb begin
      cnt_d     = '0;
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (data_in != level_q) begin
         if (cnt_q == DB_LAST) begin
            level_d   = ~level_q;
            press_d   = ~level_q;
            release_d = level_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Repeat FSM: down-counter reloads for the initial delay, then for each period
   always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      if (release_d) begin
         state_d   = RPT_IDLE;
         rpt_cnt_d = '0;
      end else begin
         case (state_q)
            RPT_IDLE: begin
               if (press_d && RPT_EN) begin
                  state_d   = RPT_DELAY;
                  rpt_cnt_d = DLY_LOAD;
               end
            end
            RPT_DELAY, RPT_REPEAT: begin
               if (rpt_cnt_q == '0) begin
                  repeat_d  = 1'b1;
                  state_d   = RPT_REPEAT;
                  rpt_cnt_d = PER_LOAD;
               end else begin
                  rpt_cnt_d = rpt_cnt_q - 1'b1;
               end
            end
            default: begin
               state_d   = RPT_IDLE;
               rpt_cnt_d = '0;
            end
         endcase
      end
   end

   // State and registered outputs; reset discards any bounce or hold progress
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         cnt_q     <= '0;
         rpt_cnt_q <= '0;
         level_q   <= 1'b0;
         press_q   <= 1'b0;
         release_q <= 1'b0;
         repeat_q  <= 1'b0;
         state_q   <= RPT_IDLE;
      end else begin
         cnt_q     <= cnt_d;
         rpt_cnt_q <= rpt_cnt_d;
         level_q   <= level_d;
         press_q   <= press_d;
         release_q <= release_d;
         repeat_q  <= repeat_d;
         state_q   <= state_d;
      end
   end

   assign level_out   = level_q;
   assign press_out   = press_q;
   assign release_out = release_q;
   assign repeat_out  = repeat_q;

endmodule

// File: rtl/button_debouncer.sv
// button_debouncer: WIDTH independent debounced channels with edge and repeat pulses
module button_debouncer
   import input_pkg::*;
#(
   parameter int WIDTH                = 4,
   parameter int DEBOUNCE_CYCLES      = 1000000,
   parameter int REPEAT_DELAY_CYCLES  = 50000000,
   parameter int REPEAT_PERIOD_CYCLES = 10000000
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] data_in,
   output logic [WIDTH-1:0] level_out,
   output logic [WIDTH-1:0] press_out,
   output logic [WIDTH-1:0] release_out,
   output logic [WIDTH-1:0] repeat_out
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_ch
      debounce_channel #(
         .DEBOUNCE_CYCLES      (DEBOUNCE_CYCLES),
         .REPEAT_DELAY_CYCLES  (REPEAT_DELAY_CYCLES),
         .REPEAT_PERIOD_CYCLES (REPEAT_PERIOD_CYCLES)
      ) u_ch (
         .clk_in      (clk_in),
         .rst_in      (rst_in),
         .data_in     (data_in[i]),
         .level_out   (level_out[i]),
         .press_out   (press_out[i]),
         .release_out (release_out[i]),
         .repeat_out  (repeat_out[i])
      );
   end

endmodule

// File: tb/tb_button_debouncer.sv
// tb_button_debouncer: directed cycle-by-cycle scoreboard check of button_debouncer
module tb_button_debouncer;

   logic       clk_in = 1'b0;
   logic       rst_in = 1'b1;
   logic [1:0] data_in = 2'b00;
   logic [1:0] level_out, press_out, release_out, repeat_out;

   logic [7:0] exp_q[$];
   int         vectors = 0;
   int         miscompares = 0;

   button_debouncer #(
      .WIDTH                (2),
      .DEBOUNCE_CYCLES      (4),
      .REPEAT_DELAY_CYCLES  (10),
      .REPEAT_PERIOD_CYCLES (3)
   ) dut (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .data_in     (data_in),
      .level_out   (level_out),
      .press_out   (press_out),
      .release_out (release_out),
      .repeat_out  (repeat_out)
   );

   always #5 clk_in = ~clk_in;

   // Drive one cycle, queue the outputs required after the edge, then pop and compare
   task automatic step(input string tag, input logic r, input logic [1:0] d,
                       input logic [1:0] lv, input logic [1:0] pr,
                       input logic [1:0] rl, input logic [1:0] rp);
      logic [7:0] obs, want;
      rst_in  = r;
      data_in = d;
      exp_q.push_back({lv, pr, rl, rp});
      @(posedge clk_in);
      #1;
      want = exp_q.pop_front();
      obs  = {level_out, press_out, release_out, repeat_out};
      vectors++;
      assert (obs === want) else begin
         miscompares++;
         $error("FAIL %s @%0t: got lvl/prs/rel/rpt=%b required %b", tag, $time, obs, want);
      end
   endtask

   task automatic hold(input string tag, input int n, input logic r,
                       input logic [1:0] d, input logic [1:0] lv);
      for (int k = 0; k < n; k++) step(tag, r, d, lv, 2'b00, 2'b00, 2'b00);
   endtask

   initial begin
      // Reset with both buttons pressed, then first cycle after deassertion
      hold("reset", 2, 1'b1, 2'b11, 2'b00);
      step("post_reset", 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
      hold("idle", 3, 1'b0, 2'b00, 2'b00);

      // Three-cycle glitch on channel 0 must be ignored
      hold("glitch", 3, 1'b0, 2'b01, 2'b00);
      hold("glitch_after", 4, 1'b0, 2'b00, 2'b00);

      // Clean press: accepted on the fourth high sample
      hold("press_wait", 3, 1'b0, 2'b01, 2'b00);
      step("press", 1'b0, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00);

      // Auto-repeat at press+10, +13, +16, +19
      hold("rpt_delay", 9, 1'b0, 2'b01, 2'b01);
      step("rpt1", 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
      hold("rpt_gap1", 2, 1'b0, 2'b01, 2'b01);
      step("rpt2", 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
      hold("rpt_gap2", 2, 1'b0, 2'b01, 2'b01);
      step("rpt3", 1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01);
      hold("rpt_gap3", 2, 1'b0, 2'b01, 2'b01);

      // Release accepted exactly where the fifth repeat would have been
      step("rpt4", 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01);
      hold("rel_wait", 2, 1'b0, 2'b00, 2'b01);
      step("release", 1'b0, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00);
      hold("no_rpt_after", 10, 1'b0, 2'b00, 2'b00);

      // Reset mid-bounce on channel 1 restarts the count
      hold("bounce1", 3, 1'b0, 2'b10, 2'b00);
      step("mid_reset", 1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00);
      hold("recount", 3, 1'b0, 2'b10, 2'b00);
      step("press1", 1'b0, 2'b10, 2'b10, 2'b10, 2'b00, 2'b00);
      hold("hold1", 2, 1'b0, 2'b10, 2'b10);
      hold("rel1_wait", 3, 1'b0, 2'b00, 2'b10);
      step("release1", 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
      hold("idle2", 4, 1'b0, 2'b00, 2'b00);

      // Independence: channel 1 follows channel 0 two cycles later
      hold("ind_wait", 2, 1'b0, 2'b01, 2'b00);
      step("ind_wait", 1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00);
      step("ind_press0", 1'b0, 2'b11, 2'b01, 2'b01, 2'b00, 2'b00);
      step("ind_hold", 1'b0, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00);
      step("ind_press1", 1'b0, 2'b11, 2'b11, 2'b10, 2'b00, 2'b00);
      hold("ind_rel_wait", 2, 1'b0, 2'b10, 2'b11);
      step("ind_rel_wait", 1'b0, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00);
      step("ind_rel0", 1'b0, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00);
      step("ind_hold", 1'b0, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00);
      step("ind_rel1", 1'b0, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00);
      hold("ind_idle", 3, 1'b0, 2'b00, 2'b00);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
